// File: rtl/pps_gen_pkg.sv
// Shared clock package: time stamp counter definitions plus the 1PPS
// generator state encoding and default flywheel period.
package pps_gen_pkg;

    localparam int unsigned TSC_SEC_W = 48;
    localparam int unsigned TSC_NS_W  = 30;

    typedef struct packed {
        logic [TSC_SEC_W-1:0] sec;
        logic [TSC_NS_W-1:0]  ns;
    } tsc_time_t;

    localparam int unsigned PPS_CLK_FREQ = 200000000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC,
        DELAY,
        PULSE,
        GAP
    } pps_state_t;

endpackage

// File: rtl/pps_cnt.sv
// Loadable down-counter that parks at zero; o_term flags the last cycle
// of a loaded interval (load N -> term after N+1 cycles).
module pps_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_term
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign o_term = (r_cnt == '0);

endmodule

// File: rtl/pps_gen.sv
// 1PPS pulse generator: aligns a programmable pulse to the TSC second marker
// and flywheels at CLK_FREQ cycles per second when the marker disappears.
module pps_gen
    import pps_gen_pkg::*;
#(
    parameter int unsigned CLK_FREQ = PPS_CLK_FREQ,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tsc_1pps,
    input  logic             enable,
    input  logic [CNT_W-1:0] offset,
    input  logic [CNT_W-1:0] width,
    input  logic             err_clr,
    output logic             pps_out,
    output logic             holdover,
    output logic             err_overrun,
    output logic [31:0]      pulse_cnt
);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] FLY_LAST = CNT_W'(CLK_FREQ - 1);

    pps_state_t       r_state;
    logic [CNT_W-1:0] r_fly;
    logic [CNT_W-1:0] r_width_m1;
    logic             r_pps;
    logic             r_hold;
    logic             r_err;
    logic [31:0]      r_pulse_cnt;

    logic             w_busy;
    logic             w_self;
    logic             w_event;
    logic             w_load;
    logic             w_term;
    logic [CNT_W-1:0] w_width_m1;
    logic [CNT_W-1:0] w_load_val;

    assign w_busy     = (r_state == DELAY) || (r_state == PULSE);
    // A real marker on the expiry cycle wins, so holdover clears and only one event fires.
    assign w_self     = (r_state == GAP) && (r_fly >= FLY_LAST) && !tsc_1pps;
    assign w_event    = enable && (r_state != IDLE) && (tsc_1pps || w_self);
    assign w_width_m1 = (width == '0) ? '0 : width - ONE;

    // The counter itself holds the offset shadow; width is shadowed for the DELAY->PULSE reload.
    assign w_load     = w_event || ((r_state == DELAY) && w_term);
    assign w_load_val = !w_event         ? r_width_m1 :
                        (offset != '0)   ? offset - ONE : w_width_m1;

    pps_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_term (w_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fly       <= '0;
            r_width_m1  <= '0;
            r_pps       <= 1'b0;
            r_hold      <= 1'b0;
            r_err       <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            if (w_event && w_busy) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            if (!enable) begin
                r_state <= IDLE;
                r_pps   <= 1'b0;
                r_hold  <= 1'b0;
            end else if (r_state == IDLE) begin
                r_state <= WAIT_SYNC;
            end else if (w_event) begin
                r_fly      <= '0;
                r_width_m1 <= w_width_m1;
                r_hold     <= w_self;
                if (offset == '0) begin
                    r_state     <= PULSE;
                    r_pps       <= 1'b1;
                    r_pulse_cnt <= r_pulse_cnt + 32'd1;
                end else begin
                    r_state <= DELAY;
                    r_pps   <= 1'b0;
                end
            end else begin
                if (r_fly != '1) r_fly <= r_fly + ONE;
                case (r_state)
                    DELAY: if (w_term) begin
                        r_state     <= PULSE;
                        r_pps       <= 1'b1;
                        r_pulse_cnt <= r_pulse_cnt + 32'd1;
                    end
                    PULSE: if (w_term) begin
                        r_state <= GAP;
                        r_pps   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pps_out     = r_pps;
    assign holdover    = r_hold;
    assign err_overrun = r_err;
    assign pulse_cnt   = r_pulse_cnt;

endmodule

// File: tb/tb_pps_gen.sv
// Bench for pps_gen: time-arithmetic reference model (event time, rise time,
// fall time) checked every cycle, plus directed literal checks.
module tb_pps_gen;
    localparam int unsigned CF = 1000;
    localparam int          CW = 32;

    logic          clk = 1'b0, rst = 1'b1;
    logic          tsc_1pps = 1'b0, enable = 1'b0, err_clr = 1'b0;
    logic [CW-1:0] offset = '0, width = '0;
    logic          pps_out, holdover, err_overrun;
    logic [31:0]   pulse_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pps_gen #(.CLK_FREQ(CF), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .tsc_1pps    (tsc_1pps),
        .enable      (enable),
        .offset      (offset),
        .width       (width),
        .err_clr     (err_clr),
        .pps_out     (pps_out),
        .holdover    (holdover),
        .err_overrun (err_overrun),
        .pulse_cnt   (pulse_cnt)
    );

    always #5 clk = ~clk;

    // Model: after enable the block waits for a marker; once running, the
    // pulse occupies cycles [rise, fall) measured from the last event.
    localparam int M_OFF = 0, M_WAIT = 1, M_RUN = 2;
    int          m_mode = M_OFF;
    longint      mc = 0, m_ev = 0, m_rise = 0, m_fall = 0;
    bit          m_hold = 1'b0, m_err = 1'b0;
    logic [31:0] m_cnt = '0;
    logic        preset_req = 1'b0;
    logic [31:0] preset_val = '0;

    always @(posedge clk or posedge rst or posedge preset_req) begin
        if (rst) begin
            m_mode = M_OFF; m_hold = 1'b0; m_err = 1'b0; m_cnt = '0;
        end else if (preset_req) begin
            m_cnt = preset_val;
        end else begin : step
            bit self_ev, ovr;
            self_ev = 1'b0; ovr = 1'b0;
            if (!enable) begin
                m_mode = M_OFF; m_hold = 1'b0;
            end else if (m_mode == M_OFF) begin
                m_mode = M_WAIT;
            end else begin
                self_ev = (m_mode == M_RUN) && (mc >= m_fall) && (mc - m_ev >= longint'(CF)) && !tsc_1pps;
                if (tsc_1pps || self_ev) begin
                    ovr    = (m_mode == M_RUN) && (mc < m_fall);
                    m_ev   = mc;
                    m_rise = mc + longint'(offset) + 1;
                    m_fall = m_rise + ((width == '0) ? 64'd1 : longint'(width));
                    m_mode = M_RUN;
                    m_hold = self_ev;
                end
            end
            if (ovr) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            mc++;
            if (m_mode == M_RUN && mc == m_rise) m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    task automatic check_model();
        bit exp_pps;
        exp_pps = (m_mode == M_RUN) && (mc >= m_rise) && (mc < m_fall);
        cmp("m_pps_out", {31'd0, pps_out}, {31'd0, exp_pps});
        cmp("m_holdover", {31'd0, holdover}, {31'd0, m_hold});
        cmp("m_err_overrun", {31'd0, err_overrun}, {31'd0, m_err});
        cmp("m_pulse_cnt", pulse_cnt, m_cnt);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_model();
        end
    endtask

    task automatic pulse_tsc();
        tsc_1pps = 1'b1;
        tick(1);
        tsc_1pps = 1'b0;
    endtask

    initial begin
        tick(3);
        cmp("rst_pps", {31'd0, pps_out}, 32'd0);
        cmp("rst_hold", {31'd0, holdover}, 32'd0);
        cmp("rst_err", {31'd0, err_overrun}, 32'd0);
        cmp("rst_cnt", pulse_cnt, 32'd0);
        rst = 1'b0;
        tick(2);

        // Offset 0, width 10: high on event+1 .. event+10
        enable = 1'b1; offset = 0; width = 10;
        tick(5);
        pulse_tsc();
        cmp("t1_rise", {31'd0, pps_out}, 32'd1);
        cmp("t1_cnt", pulse_cnt, 32'd1);
        tick(9);  cmp("t1_last", {31'd0, pps_out}, 32'd1);
        tick(1);  cmp("t1_fall", {31'd0, pps_out}, 32'd0);

        // Offset 250, width 100, markers every 1000 (coincide with flywheel expiry)
        tick(100);
        offset = 250; width = 100;
        for (int k = 0; k < 3; k++) begin
            pulse_tsc();
            cmp("t2_hold", {31'd0, holdover}, 32'd0);
            tick(249); cmp("t2_pre", {31'd0, pps_out}, 32'd0);
            tick(1);   cmp("t2_rise", {31'd0, pps_out}, 32'd1);
            tick(99);  cmp("t2_last", {31'd0, pps_out}, 32'd1);
            tick(1);   cmp("t2_fall", {31'd0, pps_out}, 32'd0);
            tick(649);
        end
        cmp("t2_err", {31'd0, err_overrun}, 32'd0);

        // Two real markers at offset 5, then flywheel, then a late marker
        offset = 5; width = 10;
        pulse_tsc();
        tick(999);
        pulse_tsc();
        tick(999); cmp("t3_hold_pre", {31'd0, holdover}, 32'd0);
        tick(1);   cmp("t3_hold_set", {31'd0, holdover}, 32'd1);
        tick(4);   cmp("t3_fly_pre", {31'd0, pps_out}, 32'd0);
        tick(1);   cmp("t3_fly_rise", {31'd0, pps_out}, 32'd1);
        tick(2294);
        pulse_tsc();
        cmp("t3_hold_clr", {31'd0, holdover}, 32'd0);
        tick(4);   cmp("t3_res_pre", {31'd0, pps_out}, 32'd0);
        tick(1);   cmp("t3_res_rise", {31'd0, pps_out}, 32'd1);
        cmp("t3_cnt", pulse_cnt, 32'd10);

        // Overrun: marker during a long pulse resyncs timing
        tick(100);
        offset = 900; width = 200;
        pulse_tsc();
        tick(899); cmp("t4_pre", {31'd0, pps_out}, 32'd0);
        tick(1);   cmp("t4_rise", {31'd0, pps_out}, 32'd1);
        tick(49);
        pulse_tsc();
        cmp("t4_drop", {31'd0, pps_out}, 32'd0);
        cmp("t4_err", {31'd0, err_overrun}, 32'd1);
        tick(899); cmp("t4_re_pre", {31'd0, pps_out}, 32'd0);
        tick(1);   cmp("t4_re_rise", {31'd0, pps_out}, 32'd1);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        cmp("t4_clr", {31'd0, err_overrun}, 32'd0);

        // Width changed during DELAY only affects the next second
        offset = 20; width = 10;
        tick(300);
        pulse_tsc();
        tick(4);  width = 50;
        tick(15); cmp("t5_pre", {31'd0, pps_out}, 32'd0);
        tick(1);  cmp("t5_rise", {31'd0, pps_out}, 32'd1);
        tick(9);  cmp("t5_last10", {31'd0, pps_out}, 32'd1);
        tick(1);  cmp("t5_fall10", {31'd0, pps_out}, 32'd0);
        tick(169);
        pulse_tsc();
        tick(69); cmp("t5_last50", {31'd0, pps_out}, 32'd1);
        tick(1);  cmp("t5_fall50", {31'd0, pps_out}, 32'd0);

        // Pulse counter wrap from a preset value
        force dut.r_pulse_cnt = 32'hFFFF_FFFE;
        preset_val = 32'hFFFF_FFFE; preset_req = 1'b1;
        #1;
        release dut.r_pulse_cnt;
        preset_req = 1'b0;
        pulse_tsc();
        tick(20);  cmp("t5_cnt_max", pulse_cnt, 32'hFFFF_FFFF);
        tick(179);
        pulse_tsc();
        tick(20);  cmp("t5_cnt_wrap", pulse_cnt, 32'd0);

        // Enable dropped mid-pulse, marker while idle is ignored
        enable = 1'b0;
        tick(1);  cmp("t6_dis", {31'd0, pps_out}, 32'd0);
        tick(5);
        enable = 1'b1;
        pulse_tsc();
        offset = 20;
        tick(25); cmp("t6_ignored", {31'd0, pps_out}, 32'd0);
        offset = 0; width = 30;
        pulse_tsc();
        cmp("t6_rise", {31'd0, pps_out}, 32'd1);
        tick(5);
        rst = 1'b1;
        #1;
        cmp("t6_rst_pps", {31'd0, pps_out}, 32'd0);
        cmp("t6_rst_cnt", pulse_cnt, 32'd0);
        cmp("t6_rst_hold", {31'd0, holdover}, 32'd0);
        cmp("t6_rst_err", {31'd0, err_overrun}, 32'd0);
        tick(3);
        rst = 1'b0;
        tick(1500);
        cmp("t6_no_fly", {31'd0, pps_out}, 32'd0);
        cmp("t6_no_cnt", pulse_cnt, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 20000; i++) begin
            tsc_1pps = ($urandom_range(0, 699) == 0);
            err_clr  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 2999) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            if ($urandom_range(0, 99) == 0) offset = $urandom_range(0, 400);
            if ($urandom_range(0, 99) == 0) width  = $urandom_range(0, 400);
            tick(1);
        end
        tsc_1pps = 1'b0; err_clr = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
